// File: rtl/corelet_ctrl_pkg.sv
// Shared types and constants for the corelet sequencer: FSM states and
// the bit positions of the 5-bit corelet instruction bus.
package corelet_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_WLOAD, S_WKERN, S_WFLUSH, S_XLOAD, S_EXEC, S_DONE
   } state_t;

   localparam int L0_RD = 4;
   localparam int L0_WR = 3;
   localparam int MODE  = 2;
   localparam int EXEC  = 1;
   localparam int WLOAD = 0;

   function automatic int max3(int a, int b, int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/corelet_ctrl_if.sv
// Bundle between the sequencer and its surroundings: host control on one
// side, corelet instruction/OFIFO and SRAM ports on the other.
interface corelet_ctrl_if #(parameter int addr_w = 11);

   logic              start, mode_in, acc;
   logic [addr_w-1:0] x_base, w_base, p_base;
   logic              ofifo_valid;
   logic [4:0]        inst;
   logic              ofifo_rd, sfu_en;
   logic              xmem_en;
   logic [addr_w-1:0] xmem_addr;
   logic              pmem_rd;
   logic [addr_w-1:0] pmem_rd_addr;
   logic              pmem_wr;
   logic [addr_w-1:0] pmem_wr_addr;
   logic              busy, done;

   modport master (
      input  start, mode_in, acc, x_base, w_base, p_base, ofifo_valid,
      output inst, ofifo_rd, sfu_en, xmem_en, xmem_addr,
             pmem_rd, pmem_rd_addr, pmem_wr, pmem_wr_addr, busy, done
   );

   modport slave (
      output start, mode_in, acc, x_base, w_base, p_base, ofifo_valid,
      input  inst, ofifo_rd, sfu_en, xmem_en, xmem_addr,
             pmem_rd, pmem_rd_addr, pmem_wr, pmem_wr_addr, busy, done
   );

endinterface

// File: rtl/corelet_wr_delay.sv
// Delays each OFIFO pop and its psum address by wr_lat cycles so the pmem
// write lines up with the corelet output; address is zero when not valid.
module corelet_wr_delay #(
   parameter int wr_lat = 3,
   parameter int addr_w = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_vld,
   input  logic [addr_w-1:0] in_addr,
   output logic              out_vld,
   output logic [addr_w-1:0] out_addr,
   output logic              busy
);

   logic [wr_lat-1:0]             vld_pipe;
   logic [wr_lat-1:0][addr_w-1:0] addr_pipe;

   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_pipe  <= '0;
         addr_pipe <= '0;
      end else begin
         vld_pipe[0]  <= in_vld;
         addr_pipe[0] <= in_vld ? in_addr : '0;
         for (int i = 1; i < wr_lat; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            addr_pipe[i] <= addr_pipe[i-1];
         end
      end
   end

   assign out_vld  = vld_pipe[wr_lat-1];
   assign out_addr = addr_pipe[wr_lat-1];
   assign busy     = |vld_pipe;

endmodule

// File: rtl/corelet_ctrl.sv
// Layer sequencer for one corelet: per kernel pass loads weights, loads
// activations, executes and drains the OFIFO into pmem via the SFU path.
module corelet_ctrl #(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int len_kij = 9,
   parameter int len_nij = 36,
   parameter int addr_w  = 11,
   parameter int wr_lat  = 3
) (
   input logic           clk,
   input logic           reset,
   corelet_ctrl_if.master bus
);
   import corelet_ctrl_pkg::*;

   localparam int CW = $clog2(max3(col + 1, row + col, len_nij + 1) + 1);
   localparam int KW = $clog2(len_kij + 1);
   localparam int RW = $clog2(len_nij + 1);

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [KW-1:0]     kij;
   logic [RW-1:0]     rd_cnt;
   logic              mode_q, acc_q;
   logic [4:0]        inst_q;
   logic              xmem_en_q, sfu_en_q, busy_q, done_q;
   logic [addr_w-1:0] xmem_addr_q;
   logic              accum, rd_fire, wr_vld, wr_busy;
   logic [addr_w-1:0] rd_addr, wr_addr;

   assign accum   = acc_q && (kij != '0);
   assign rd_fire = (state == S_EXEC) && bus.ofifo_valid && (rd_cnt < RW'(len_nij));
   assign rd_addr = bus.p_base + addr_w'(rd_cnt);

   // Outputs are registered: each cycle shows the decode of the previous state cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         kij         <= '0;
         rd_cnt      <= '0;
         mode_q      <= 1'b0;
         acc_q       <= 1'b0;
         inst_q      <= '0;
         xmem_en_q   <= 1'b0;
         xmem_addr_q <= '0;
         sfu_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         inst_q        <= '0;
         inst_q[L0_WR] <= xmem_en_q;
         inst_q[MODE]  <= (state == S_IDLE) ? (bus.start & bus.mode_in)
                                            : ((state != S_DONE) & mode_q);
         busy_q        <= (state == S_IDLE) ? bus.start : (state != S_DONE);
         done_q        <= (state == S_DONE);
         sfu_en_q      <= (state != S_IDLE) && (state != S_DONE) && accum;
         xmem_en_q     <= 1'b0;
         xmem_addr_q   <= '0;
         cnt           <= cnt + 1'b1;
         if (rd_fire) rd_cnt <= rd_cnt + 1'b1;

         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (bus.start) begin
                  mode_q <= bus.mode_in;
                  acc_q  <= bus.acc;
                  kij    <= '0;
                  rd_cnt <= '0;
                  state  <= S_WLOAD;
               end
            end
            S_WLOAD: begin
               if (cnt < CW'(col)) begin
                  xmem_en_q   <= 1'b1;
                  xmem_addr_q <= bus.w_base + addr_w'(kij) * addr_w'(col) + addr_w'(cnt);
               end else begin
                  cnt   <= '0;
                  state <= S_WKERN;
               end
            end
            S_WKERN: begin
               inst_q[L0_RD] <= 1'b1;
               inst_q[WLOAD] <= 1'b1;
               if (cnt == CW'(col - 1)) begin
                  cnt   <= '0;
                  state <= S_WFLUSH;
               end
            end
            S_WFLUSH: begin
               if (cnt == CW'(row + col - 1)) begin
                  cnt   <= '0;
                  state <= S_XLOAD;
               end
            end
            S_XLOAD: begin
               if (cnt < CW'(len_nij)) begin
                  xmem_en_q   <= 1'b1;
                  xmem_addr_q <= bus.x_base + addr_w'(cnt);
               end else begin
                  cnt    <= '0;
                  rd_cnt <= '0;
                  state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (cnt < CW'(len_nij)) begin
                  inst_q[L0_RD] <= 1'b1;
                  inst_q[EXEC]  <= 1'b1;
               end else begin
                  // Hold the exec counter; the pass ends once every row is written back.
                  cnt <= cnt;
                  if ((rd_cnt == RW'(len_nij)) && !wr_busy) begin
                     cnt <= '0;
                     if (kij == KW'(len_kij - 1)) begin
                        state <= S_DONE;
                     end else begin
                        kij   <= kij + 1'b1;
                        state <= S_WLOAD;
                     end
                  end
               end
            end
            S_DONE: begin
               cnt   <= '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   corelet_wr_delay #(.wr_lat(wr_lat), .addr_w(addr_w)) u_wr_delay (
      .clk     (clk),
      .reset   (reset),
      .in_vld  (rd_fire),
      .in_addr (rd_addr),
      .out_vld (wr_vld),
      .out_addr(wr_addr),
      .busy    (wr_busy)
   );

   assign bus.inst         = inst_q;
   assign bus.ofifo_rd     = rd_fire;
   assign bus.sfu_en       = sfu_en_q;
   assign bus.xmem_en      = xmem_en_q;
   assign bus.xmem_addr    = xmem_addr_q;
   assign bus.pmem_rd      = rd_fire && accum;
   assign bus.pmem_rd_addr = (rd_fire && accum) ? rd_addr : '0;
   assign bus.pmem_wr      = wr_vld;
   assign bus.pmem_wr_addr = wr_addr;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Bench for corelet_ctrl: per-cycle trace against a phase-offset model of a
// layer, table of layer configurations, plus reset and stray-start sequences.
module tb_corelet_ctrl;

   localparam int ROW = 4, COL = 4, LKIJ = 2, LNIJ = 4, AW = 11, WL = 3;
   localparam int XS  = 3 * COL + ROW + 2;  // first activation-load cycle of a pass

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   corelet_ctrl_if #(.addr_w(AW)) bus ();

   corelet_ctrl #(
      .row(ROW), .col(COL), .len_kij(LKIJ), .len_nij(LNIJ), .addr_w(AW), .wr_lat(WL)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct packed {
      logic          busy, done;
      logic [4:0]    inst;
      logic          ofifo_rd, sfu_en, xmem_en;
      logic [AW-1:0] xmem_addr;
      logic          pmem_rd;
      logic [AW-1:0] pmem_rd_addr;
      logic          pmem_wr;
      logic [AW-1:0] pmem_wr_addr;
   } obs_t;

   typedef struct {
      logic          mode, acc;
      logic [AW-1:0] xb, wb, pb;
      int            vpat;   // 0 always valid, 1 random, 2 pattern 1,0,0,1
      logic          poke;   // pulse start in the middle of EXEC
      int            exp_wr, exp_prd, exp_done;
   } vec_t;

   vec_t tbl[5];
   int   checks = 0;
   int   errors = 0;

   function automatic obs_t sample();
      obs_t o;
      o.busy = bus.busy;         o.done = bus.done;
      o.inst = bus.inst;         o.ofifo_rd = bus.ofifo_rd;
      o.sfu_en = bus.sfu_en;     o.xmem_en = bus.xmem_en;
      o.xmem_addr = bus.xmem_addr;
      o.pmem_rd = bus.pmem_rd;   o.pmem_rd_addr = bus.pmem_rd_addr;
      o.pmem_wr = bus.pmem_wr;   o.pmem_wr_addr = bus.pmem_wr_addr;
      return o;
   endfunction

   task automatic check_obs(input string nm, input int t, input obs_t a, input obs_t e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s t=%0d got=%h exp=%h", nm, t, a, e);
      end
   endtask

   task automatic check_int(input string nm, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", nm, a, e);
      end
   endtask

   // Expected trace comes from pass-relative cycle offsets and a write queue.
   task automatic run_layer(input vec_t v, output int nwr, output int nprd, output int ndone);
      int t, p, P, reads, nextP, end_t, u, k;
      int wq_t[$];
      logic [AW-1:0] wq_a[$];
      logic vld;
      obs_t e, a;
      nwr = 0; nprd = 0; ndone = 0;
      bus.mode_in = v.mode; bus.acc = v.acc;
      bus.x_base = v.xb; bus.w_base = v.wb; bus.p_base = v.pb;
      bus.ofifo_valid = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      t = 0; p = 0; P = 0; reads = 0; nextP = -1; end_t = -1; k = 0;
      forever begin
         if (t == nextP) begin
            nextP = -1;
            if (p == LKIJ - 1) end_t = t;
            else begin p++; P = t; reads = 0; k = 0; end
         end
         u = t - P;
         vld = 1'b0;
         if (end_t < 0 && u >= XS + LNIJ + 1) begin
            case (v.vpat)
               0:       vld = 1'b1;
               1:       vld = 1'($urandom_range(0, 1));
               default: vld = (k % 4 == 0) || (k % 4 == 3);
            endcase
            k++;
         end
         bus.ofifo_valid = vld;
         bus.start = v.poke && (end_t < 0) && (u == XS + LNIJ + 2);
         #1;
         e = '0;
         e.busy    = (end_t < 0) || (t == end_t);
         e.done    = (end_t >= 0) && (t == end_t + 1);
         e.inst[2] = e.busy && v.mode;
         if (end_t >= 0)  e.sfu_en = (t == end_t) && v.acc && (p > 0);
         else if (u == 0) e.sfu_en = v.acc && (p > 1);
         else             e.sfu_en = v.acc && (p > 0);
         if (end_t < 0) begin
            if (u >= 1 && u <= COL) begin
               e.xmem_en = 1'b1;
               e.xmem_addr = AW'(int'(v.wb) + p * COL + u - 1);
            end
            if (u >= XS && u <= XS + LNIJ - 1) begin
               e.xmem_en = 1'b1;
               e.xmem_addr = AW'(int'(v.xb) + u - XS);
            end
            e.inst[3] = (u >= 2 && u <= COL + 1) || (u >= XS + 1 && u <= XS + LNIJ);
            if (u >= COL + 2 && u <= 2 * COL + 1) begin e.inst[4] = 1'b1; e.inst[0] = 1'b1; end
            if (u >= XS + LNIJ + 1 && u <= XS + 2 * LNIJ) begin e.inst[4] = 1'b1; e.inst[1] = 1'b1; end
         end
         if (vld && reads < LNIJ) begin
            e.ofifo_rd = 1'b1;
            if (v.acc && p > 0) begin
               e.pmem_rd = 1'b1;
               e.pmem_rd_addr = AW'(int'(v.pb) + reads);
            end
            wq_t.push_back(t + WL);
            wq_a.push_back(AW'(int'(v.pb) + reads));
            reads++;
            if (reads == LNIJ) nextP = t + WL + 2;
         end
         if (wq_t.size() > 0 && wq_t[0] == t) begin
            e.pmem_wr = 1'b1;
            e.pmem_wr_addr = wq_a[0];
            void'(wq_t.pop_front());
            void'(wq_a.pop_front());
         end
         a = sample();
         check_obs("trace", t, a, e);
         nwr   += int'(a.pmem_wr);
         nprd  += int'(a.pmem_rd);
         ndone += int'(a.done);
         if (end_t >= 0 && t == end_t + 2) break;
         if (t >= 600) begin
            checks++; errors++;
            $display("FAIL layer_timeout got=%0d exp=<600", t);
            break;
         end
         @(negedge clk);
         t++;
      end
      bus.ofifo_valid = 1'b0;
      bus.start = 1'b0;
   endtask

   initial begin
      int nwr, nprd, ndone, n, cyc;
      tbl[0] = '{1'b0, 1'b0, 11'd100,  11'd16,   11'd200,  0, 1'b0, 8, 0, 1};
      tbl[1] = '{1'b1, 1'b1, 11'd300,  11'd16,   11'd500,  0, 1'b1, 8, 4, 1};
      tbl[2] = '{1'b0, 1'b1, 11'd7,    11'd40,   11'd64,   2, 1'b0, 8, 4, 1};
      tbl[3] = '{1'b1, 1'b1, 11'd2046, 11'd2045, 11'd2046, 1, 1'b1, 8, 4, 1};
      tbl[4] = '{1'b0, 1'b0, 11'd0,    11'd0,    11'd0,    1, 1'b0, 8, 0, 1};

      bus.start = 1'b1; bus.mode_in = 1'b1; bus.acc = 1'b1;
      bus.x_base = '0; bus.w_base = '0; bus.p_base = '0; bus.ofifo_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check_obs("reset_hold", i, sample(), '0);
      end
      reset = 1'b1; bus.start = 1'b0; bus.ofifo_valid = 1'b0;
      @(negedge clk); #1;
      check_obs("idle_after_reset", 0, sample(), '0);

      for (int i = 0; i < 5; i++) begin
         run_layer(tbl[i], nwr, nprd, ndone);
         check_int($sformatf("wr_count[%0d]", i), nwr, tbl[i].exp_wr);
         check_int($sformatf("prd_count[%0d]", i), nprd, tbl[i].exp_prd);
         check_int($sformatf("done_count[%0d]", i), ndone, tbl[i].exp_done);
      end

      // Abort with two pops in the write-delay pipeline.
      bus.mode_in = 1'b0; bus.acc = 1'b0; bus.x_base = 11'd10; bus.w_base = 11'd20;
      bus.p_base = 11'd30; bus.ofifo_valid = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0; cyc = 0;
      while (n < 2 && cyc < 300) begin
         #1;
         if (bus.ofifo_rd) n++;
         if (n < 2) begin @(negedge clk); cyc++; end
      end
      check_int("rst_mid_reach", n, 2);
      reset = 1'b0; bus.ofifo_valid = 1'b0;
      @(negedge clk); #1;
      check_obs("rst_mid_clear", 0, sample(), '0);
      reset = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk); #1;
         check_obs("rst_mid_quiet", i, sample(), '0);
      end
      run_layer(tbl[1], nwr, nprd, ndone);
      check_int("post_rst_wr", nwr, tbl[1].exp_wr);
      check_int("post_rst_done", ndone, tbl[1].exp_done);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/corelet_ctrl.md
Name: corelet_ctrl

Overview:
- Sequencer for one corelet: drives its 5-bit inst bus, ofifo_rd and sfu_en, plus the activation/weight SRAM (xmem) and psum SRAM (pmem) ports.
- Runs a full convolution layer as len_kij kernel passes; each pass loads weights, loads activations, executes and drains the OFIFO.
- Psums go to pmem, accumulated through the SFU from the second pass onward.
- Sits between the top-level testbench/host and the corelet + SRAM banks.

Parameters:
row, 8, MAC array rows (L0 lanes)
col, 8, MAC array columns (OFIFO lanes)
len_kij, 9, kernel passes per layer
len_nij, 36, output pixels per pass (activation vectors)
addr_w, 11, SRAM address width
wr_lat, 3, cycles from ofifo_rd to corresponding corelet out valid for pmem write

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-low; reset==0 at a posedge clears all state
start  in  1  one-cycle pulse; starts a layer when in IDLE
mode_in  in  1  dataflow mode; sampled on accepted start, driven on inst[2]
acc  in  1  enable SFU accumulation for passes kij>=1
x_base  in  addr_w  activation base address in xmem
w_base  in  addr_w  weight base address in xmem
p_base  in  addr_w  psum base address in pmem
ofifo_valid  in  1  corelet OFIFO has a full row
inst  out  5  {l0_rd, l0_wr, mode, exec, weightload} to corelet
ofifo_rd  out  1  OFIFO pop
sfu_en  out  1  corelet selects SFU path
xmem_en  out  1  xmem read enable (1-cycle read latency)
xmem_addr  out  addr_w  xmem read address
pmem_rd  out  1  pmem read (psum operand for SFU)
pmem_rd_addr  out  addr_w  pmem read address
pmem_wr  out  1  pmem write of corelet out
pmem_wr_addr  out  addr_w  pmem write address
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of layer

Behaviour:
- Reset: state=IDLE; kij=0; all counters 0; every output 0; write-delay pipeline flushed. Reset mid-operation aborts immediately, no further pmem writes.
- States: IDLE, WLOAD, WKERN, WFLUSH, XLOAD, EXEC, DONE.
- IDLE: start=1 latches mode_in, sets kij=0 -> WLOAD. start in any other state ignored.
- WLOAD (col+1 cycles):
  - cycles 0..col-1: xmem_en=1, xmem_addr=w_base+kij*col+i.
  - l0_wr = xmem_en delayed 1 cycle, so col writes land on cycles 1..col.
  - -> WKERN.
- WKERN (col cycles): l0_rd=1, weightload=1 -> WFLUSH.
- WFLUSH (row+col cycles): inst={0,0,mode,0,0} -> XLOAD.
- XLOAD (len_nij+1 cycles): xmem_addr=x_base+i for i<len_nij; l0_wr delayed 1 cycle -> EXEC.
- EXEC:
  - l0_rd=1, exec=1 for the first len_nij cycles, then inst exec/l0_rd=0.
  - Drain runs concurrently: ofifo_rd=ofifo_valid && (rd_cnt<len_nij); rd_cnt increments on each ofifo_rd.
  - With ofifo_rd and (acc && kij!=0): pmem_rd=1, pmem_rd_addr=p_base+rd_cnt.
  - sfu_en = acc && kij!=0, constant through the pass.
  - pmem_wr/pmem_wr_addr = ofifo_rd/(p_base+rd_cnt) delayed wr_lat cycles via shift register.
  - Leave EXEC when rd_cnt==len_nij and the delay pipeline is empty.
  - If kij==len_kij-1 -> DONE, else kij++ -> WLOAD.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- ofifo_valid low stalls draining without bound; no timeout.
- mode bit held from start until IDLE; inst[2]=0 in IDLE.
- Counters sized clog2(max+1); address arithmetic modulo 2^addr_w (wrap allowed, not flagged).

Decomposition:
- Package corelet_ctrl_pkg: state enum, inst bit-index constants (L0_RD=4, L0_WR=3, MODE=2, EXEC=1, WLOAD=0).
- Sub-module corelet_wr_delay: parameterised (wr_lat, addr_w) shift register carrying {valid, addr}, synchronous active-low clear.

Test Plan:
- Reset held 0 for 3 cycles, start=1 meanwhile -> all outputs 0, busy=0, state stays IDLE.
- row=col=4, len_kij=1, len_nij=4, w_base=16, start; model asserts ofifo_valid continuously from EXEC cycle 6 ->
  - xmem_addr 16..19, l0_wr on 4 cycles, weightload on 4 cycles, 8 idle flush cycles, xmem_addr x_base..+3;
  - pmem_wr to p_base..p_base+3 exactly 3 cycles after each ofifo_rd; done pulses once.
- len_kij=2, acc=1 ->
  - pass 0: sfu_en=0, no pmem_rd;
  - pass 1: sfu_en=1, pmem_rd_addr equals pmem_wr_addr of the same row 3 cycles later;
  - weight addr for pass 1 = w_base+col.
- ofifo_valid toggled 1,0,0,1 during drain -> ofifo_rd only on valid cycles, rd_cnt ends at len_nij, no extra pmem_wr.
- start pulsed during EXEC -> ignored, kij unchanged, single done.
- reset=0 in EXEC with 2 writes in flight -> next cycle all outputs 0, no pmem_wr emitted; fresh start completes normally.
